e_mdu_sequencer: RTL and testbench
==================================

# e_mdu_sequencer

Multiply/divide sequencer for the E stage of the pipelined CPU. Accepts one MDU operation per request, latches operands, runs a fixed-latency busy countdown, and commits the result to the HI/LO architectural registers on completion. Drives `busy` to the hazard unit, which stalls the D stage on any MDU instruction while the unit is occupied. Also services MTHI/MTLO writes and supports cancellation when an exception or interrupt is taken in M.

## Interface
- `MUL_CYCLES`, default 5: busy cycles for MULT/MULTU (and MADD family when enabled); must be at least 1.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; must be at least 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  request valid this cycle (E-stage MDU instruction).
- `mdu_op`  in  4  operation code, defined in the shared package.
- `src_a`  in  32  forwarded rs value.
- `src_b`  in  32  forwarded rt value.
- `cancel`  in  1  kill this cycle's request (exception or interrupt in M, or E-stage flush); has no effect on an op already in flight.
- `busy`  out  1  equals `start` OR (counter != 0); combinational.
- `done`  out  1  one-cycle pulse, registered, in the cycle HI/LO first show a new multiply/divide result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE (counter == 0) and RUN (counter != 0).
- Accepted request: `start & ~cancel & ~(counter != 0)`.
  - A request arriving while in RUN is ignored. The hazard unit guarantees this does not happen; the bench checks that it is dropped silently.
- MTHI/MTLO accepted in IDLE: at that edge, `hi` or `lo` takes `src_a`. The counter stays 0 and `done` is not asserted.
- MULT/MULTU/DIV/DIVU accepted in IDLE:
  - latch op, `src_a` and `src_b`;
  - load the counter with MUL_CYCLES or DIV_CYCLES.
- In RUN the counter decrements by 1 each edge. On the edge where it goes from 1 to 0:
  - write `{hi,lo}` from the latched computation;
  - set `done` for the next cycle.
- Arithmetic:
  - MULT: signed 32x32 to 64-bit product; `hi` = [63:32], `lo` = [31:0].
  - MULTU: unsigned 32x32 to 64-bit product, same split.
  - DIV: signed; `lo` = quotient truncated toward zero, `hi` = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero: the full latency still elapses and `done` still pulses, but `hi` and `lo` are left unchanged.
- `cancel` together with `start`: no state changes and no busy countdown. `busy` is still high for that cycle, because it is combinational from `start`.
- Any other `mdu_op` value with `start`: treated as a no-op.

## Timing
- Reset values: `hi` = 0, `lo` = 0, counter = 0, `done` = 0, and therefore `busy` = `start`.
- Reset asserted during RUN: the op is aborted and `hi`/`lo` go to 0 asynchronously.
- Request accepted in cycle T with latency N:
  - `busy` is high in cycles T through T+N;
  - the new `hi`/`lo` are visible from cycle T+N+1;
  - `done` is high in cycle T+N+1 only.
- Back-to-back: a new request is accepted in cycle T+N+1 at the earliest.
- MTHI/MTLO in cycle T: the new value is visible in cycle T+1, and `busy` is high only in cycle T.
- The computation may be single-cycle combinational on the latched operands, or iterative, provided the result is ready by the final edge. The observable latency is fixed by the parameters.

## Configuration
- `MDU_MADD_EN` defined:
  - adds MADD, MADDU, MSUB and MSUBU opcodes with latency MUL_CYCLES;
  - the result is `{hi,lo}` as sampled at accept, plus or minus the 64-bit product (signed or unsigned), wrapping modulo 2^64.
- `MDU_MADD_EN` undefined: these opcodes are decoded as no-ops, and the accumulate path and its snapshot register are absent.

## Structure
- Shared package `mdu_pkg`:
  - `mdu_op` encoding (NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO, plus MADD/MADDU/MSUB/MSUBU under the macro);
  - default latency constants.
- One sub-module, `mdu_compute`: purely combinational. Takes the latched op and operands and produces the 64-bit `{hi,lo}` result plus a div-by-zero flag.
- The sequencer holds the counter, the operand latches, HI/LO and `done`.

## Test plan
- Reset, then MULT with `src_a` = 0xFFFFFFFE (-2) and `src_b` = 3 in cycle T: `busy` high in T..T+5; in T+6 `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFA, and `done` = 1.
- DIVU with 7 and 2: after 10 busy cycles, `lo` = 3 and `hi` = 1. DIV with -7 and 2: `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- DIV by 0 with `hi`/`lo` preloaded via MTHI 0x11 and MTLO 0x22: `done` pulses after 10 busy cycles; `hi` = 0x11 and `lo` = 0x22 are unchanged.
- MULT with `start` and `cancel` both high: `busy` high for that cycle only, no `done`, `hi`/`lo` unchanged. A second MULT issued in RUN is ignored, and only the first result appears.
- Assert `reset` in cycle T+2 of a DIVU: `busy`, `hi` and `lo` all go to 0 immediately, and no `done` follows.
- With `MDU_MADD_EN`, `hi`/`lo` = 0/5, then MADDU with 2 and 3: `lo` = 11 and `hi` = 0. Then MSUBU with 4 and 3: `{hi,lo}` = 0xFFFFFFFF_FFFFFFFF.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encoding, data widths, default latencies.
// The MADD/MADDU/MSUB/MSUBU opcodes exist only when MDU_MADD_EN is defined.
package mdu_pkg;

   localparam int unsigned DATA_W          = 32;
   localparam int unsigned OP_W            = 4;
   localparam int unsigned DEF_MUL_CYCLES  = 5;
   localparam int unsigned DEF_DIV_CYCLES  = 10;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6
`ifdef MDU_MADD_EN
      ,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
`endif
   } mdu_op_e;

   // Operation and operands captured at accept time
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } mdu_req_t;

   // Ops that take the multiply latency
   function automatic logic is_mul_op(input logic [OP_W-1:0] op);
      case (op)
         OP_MULT, OP_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_div_op(input logic [OP_W-1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/e_mdu_sequencer_if.sv
// Request/result bundle between the E stage (master) and the MDU sequencer (slave).
interface e_mdu_sequencer_if;

   logic                          start;
   logic [mdu_pkg::OP_W-1:0]      mdu_op;
   logic [mdu_pkg::DATA_W-1:0]    src_a;
   logic [mdu_pkg::DATA_W-1:0]    src_b;
   logic                          cancel;
   logic                          busy;
   logic                          done;
   logic [mdu_pkg::DATA_W-1:0]    hi;
   logic [mdu_pkg::DATA_W-1:0]    lo;

   modport master (
      output start, mdu_op, src_a, src_b, cancel,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, mdu_op, src_a, src_b, cancel,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/mdu_compute.sv
// Combinational multiply/divide datapath on the latched request.
// With MDU_MADD_EN defined it also forms the accumulate/subtract result.
module mdu_compute
   import mdu_pkg::*;
(
   input  mdu_req_t              req,
`ifdef MDU_MADD_EN
   input  logic [2*DATA_W-1:0]   acc,
`endif
   output logic [2*DATA_W-1:0]   result,
   output logic                  div_zero
);

   logic [2*DATA_W-1:0] prod_s;
   logic [2*DATA_W-1:0] prod_u;
   logic [DATA_W-1:0]   div_b;
   logic [DATA_W-1:0]   mag_a;
   logic [DATA_W-1:0]   mag_b;
   logic [DATA_W-1:0]   quo_u;
   logic [DATA_W-1:0]   rem_u;
   logic [DATA_W-1:0]   quo_m;
   logic [DATA_W-1:0]   rem_m;
   logic [DATA_W-1:0]   quo_s;
   logic [DATA_W-1:0]   rem_s;

   // Low 64 bits of a 64x64 product of the extended operands give the exact 32x32 product
   assign prod_s = {{DATA_W{req.a[DATA_W-1]}}, req.a} * {{DATA_W{req.b[DATA_W-1]}}, req.b};
   assign prod_u = {{DATA_W{1'b0}}, req.a} * {{DATA_W{1'b0}}, req.b};

   // Divisor forced nonzero so the dividers never see zero; result is discarded then anyway
   assign div_zero = is_div_op(req.op) && (req.b == '0);
   assign div_b    = (req.b == '0) ? DATA_W'(1) : req.b;

   assign quo_u = req.a / div_b;
   assign rem_u = req.a % div_b;

   // Signed divide via magnitudes: quotient truncates toward zero, remainder follows dividend
   assign mag_a = req.a[DATA_W-1] ? (DATA_W'(0) - req.a) : req.a;
   assign mag_b = div_b[DATA_W-1] ? (DATA_W'(0) - div_b) : div_b;
   assign quo_m = mag_a / mag_b;
   assign rem_m = mag_a % mag_b;
   assign quo_s = (req.a[DATA_W-1] ^ div_b[DATA_W-1]) ? (DATA_W'(0) - quo_m) : quo_m;
   assign rem_s = req.a[DATA_W-1] ? (DATA_W'(0) - rem_m) : rem_m;

   always_comb begin
      result = '0;
      case (req.op)
         OP_MULT:  result = prod_s;
         OP_MULTU: result = prod_u;
         OP_DIV:   result = {rem_s, quo_s};
         OP_DIVU:  result = {rem_u, quo_u};
`ifdef MDU_MADD_EN
         OP_MADD:  result = acc + prod_s;
         OP_MADDU: result = acc + prod_u;
         OP_MSUB:  result = acc - prod_s;
         OP_MSUBU: result = acc - prod_u;
`endif
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/e_mdu_sequencer.sv
// E-stage multiply/divide sequencer: fixed-latency busy countdown, HI/LO commit, MTHI/MTLO.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU with a HI/LO snapshot at accept.
module e_mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
   parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
)
(
   input  logic                clk,
   input  logic                reset,
   e_mdu_sequencer_if.slave    mdu
);

   localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [CNT_W-1:0]      cnt_q;
   mdu_req_t              req_q;
   logic [DATA_W-1:0]     hi_q;
   logic [DATA_W-1:0]     lo_q;
   logic                  done_q;
   logic [2*DATA_W-1:0]   result_c;
   logic                  div_zero_c;
   logic                  run_c;
   logic                  accept_c;
   logic                  launch_c;
`ifdef MDU_MADD_EN
   logic [2*DATA_W-1:0]   acc_q;
`endif

   // RUN is simply a nonzero counter; requests during RUN are dropped
   assign run_c    = (cnt_q != '0);
   assign accept_c = mdu.start & ~mdu.cancel & ~run_c;
   assign launch_c = accept_c & (is_mul_op(mdu.mdu_op) | is_div_op(mdu.mdu_op));

   assign mdu.busy = mdu.start | run_c;
   assign mdu.done = done_q;
   assign mdu.hi   = hi_q;
   assign mdu.lo   = lo_q;

   mdu_compute u_compute (
      .req      (req_q),
`ifdef MDU_MADD_EN
      .acc      (acc_q),
`endif
      .result   (result_c),
      .div_zero (div_zero_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         req_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept_c && (mdu.mdu_op == OP_MTHI)) begin
            hi_q <= mdu.src_a;
         end else if (accept_c && (mdu.mdu_op == OP_MTLO)) begin
            lo_q <= mdu.src_a;
         end else if (launch_c) begin
            req_q <= '{op: mdu.mdu_op, a: mdu.src_a, b: mdu.src_b};
            cnt_q <= is_mul_op(mdu.mdu_op) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
         end else if (run_c) begin
            cnt_q <= cnt_q - CNT_W'(1);
            // Final edge: commit unless the divisor was zero, and flag completion
            if (cnt_q == CNT_W'(1)) begin
               done_q <= 1'b1;
               if (!div_zero_c) begin
                  {hi_q, lo_q} <= result_c;
               end
            end
         end
      end
   end

`ifdef MDU_MADD_EN
   // Accumulator snapshot taken from HI/LO as they stand when the op is accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
      end else if (launch_c) begin
         acc_q <= {hi_q, lo_q};
      end
   end
`endif

endmodule

// File: tb/tb_e_mdu_sequencer.sv
// Self-checking bench for e_mdu_sequencer: directed table, corner sequences, random vs. model.
`timescale 1ns/1ps
module tb_e_mdu_sequencer;
   import mdu_pkg::*;

   localparam int unsigned MUL_LAT = 5;
   localparam int unsigned DIV_LAT = 10;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   e_mdu_sequencer_if bus ();

   e_mdu_sequencer #(.MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (bus)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          exp_busy;
      int          exp_done;
   } vec_t;

   int          nvec = 0;
   int          nerr = 0;
   int          cyc;
   int          busy_until;
   int          commit_at;
   logic [63:0] pend_res;
   bit          pend_wr;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   bit          obs_busy;
   bit          obs_done;
   int          bc;
   int          dc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: an accepted op schedules its result for cycle accept+lat+1
   task automatic model_accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned acc;
      int              lat;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = 64'(a);
      ub  = 64'(b);
      acc = {m_hi, m_lo};
      lat = 0;
      pend_wr = 1'b1;
      case (op)
         OP_MTHI:  m_hi = a;
         OP_MTLO:  m_lo = a;
         OP_MULT:  begin lat = MUL_LAT; pend_res = sa * sb; end
         OP_MULTU: begin lat = MUL_LAT; pend_res = ua * ub; end
         OP_DIV: begin
            lat = DIV_LAT;
            if (b == 32'd0) pend_wr = 1'b0;
            else pend_res = {32'(sa % sb), 32'(sa / sb)};
         end
         OP_DIVU: begin
            lat = DIV_LAT;
            if (b == 32'd0) pend_wr = 1'b0;
            else pend_res = {32'(ua % ub), 32'(ua / ub)};
         end
`ifdef MDU_MADD_EN
         OP_MADD:  begin lat = MUL_LAT; pend_res = acc + 64'(sa * sb); end
         OP_MADDU: begin lat = MUL_LAT; pend_res = acc + ua * ub; end
         OP_MSUB:  begin lat = MUL_LAT; pend_res = acc - 64'(sa * sb); end
         OP_MSUBU: begin lat = MUL_LAT; pend_res = acc - ua * ub; end
`endif
         default: ;
      endcase
      if (lat != 0) begin
         busy_until = cyc + lat;
         commit_at  = cyc + lat + 1;
      end
   endtask

   // One clock cycle: drive, check at negedge against the model, advance
   task automatic step(input logic s, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic c);
      bit run;
      bit exp_done;
      bus.start  = s;
      bus.mdu_op = op;
      bus.src_a  = a;
      bus.src_b  = b;
      bus.cancel = c;
      exp_done = (cyc == commit_at);
      if (exp_done && pend_wr) {m_hi, m_lo} = pend_res;
      run = (cyc <= busy_until);
      @(negedge clk);
      obs_busy = bus.busy;
      obs_done = bus.done;
      check("busy", 64'(bus.busy), 64'(s | run));
      check("done", 64'(bus.done), 64'(exp_done));
      check("hi", 64'(bus.hi), 64'(m_hi));
      check("lo", 64'(bus.lo), 64'(m_lo));
      if (s && !c && !run) model_accept(op, a, b);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
         bc += int'(obs_busy);
         dc += int'(obs_done);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      step(1'b1, v.op, v.a, v.b, 1'b0);
      bc = int'(obs_busy);
      dc = int'(obs_done);
      idle(13);
      check({tag, "_busy_cycles"}, 64'(bc), 64'(v.exp_busy));
      check({tag, "_done_count"}, 64'(dc), 64'(v.exp_done));
      check({tag, "_hi"}, 64'(bus.hi), 64'(v.exp_hi));
      check({tag, "_lo"}, 64'(bus.lo), 64'(v.exp_lo));
   endtask

   task automatic mid_reset();
      bus.start = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      busy_until = -1;
      commit_at  = -1;
      pend_wr    = 1'b0;
      m_hi       = '0;
      m_lo       = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc++;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[12];
      logic [3:0]  r_op;
      logic [31:0] r_a;
      logic [31:0] r_b;

      tbl[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 6,  1};
      tbl[1]  = '{OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        11, 1};
      tbl[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 11, 1};
      tbl[3]  = '{OP_MTHI,  32'h11,       32'd0,        32'h11,       32'hFFFFFFFD, 1,  0};
      tbl[4]  = '{OP_MTLO,  32'h22,       32'd0,        32'h11,       32'h22,       1,  0};
      tbl[5]  = '{OP_DIV,   32'd5,        32'd0,        32'h11,       32'h22,       11, 1};
      tbl[6]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 6,  1};
      tbl[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 11, 1};
      tbl[8]  = '{OP_NOP,   32'h5,        32'h6,        32'h0,        32'h80000000, 1,  0};
      tbl[9]  = '{4'd15,    32'h5,        32'h6,        32'h0,        32'h80000000, 1,  0};
      tbl[10] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 11, 1};
      tbl[11] = '{OP_MULT,  32'h7FFFFFFF, 32'd2,        32'h0,        32'hFFFFFFFE, 6,  1};

      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.mdu_op = '0;
      bus.src_a  = '0;
      bus.src_b  = '0;
      bus.cancel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_hi", 64'(bus.hi), 64'd0);
      check("reset_lo", 64'(bus.lo), 64'd0);
      bus.start = 1'b1;
      #1;
      check("reset_busy_follows_start", 64'(bus.busy), 64'd1);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      reset      = 1'b0;
      cyc        = 0;
      busy_until = -1;
      commit_at  = -1;
      pend_wr    = 1'b0;
      m_hi       = '0;
      m_lo       = '0;

      for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      // start with cancel: one busy cycle, nothing else
      step(1'b1, OP_MULT, 32'd7, 32'd9, 1'b1);
      bc = int'(obs_busy);
      dc = 0;
      idle(8);
      check("cancel_busy_cycles", 64'(bc), 64'd1);
      check("cancel_done_count", 64'(dc), 64'd0);
      check("cancel_hi", 64'(bus.hi), 64'h0);
      check("cancel_lo", 64'(bus.lo), 64'hFFFFFFFE);

      // second MULT during RUN is dropped
      step(1'b1, OP_MULT, 32'd3, 32'd4, 1'b0);
      bc = int'(obs_busy);
      dc = 0;
      idle(1);
      step(1'b1, OP_MULT, 32'd100, 32'd100, 1'b0);
      bc += int'(obs_busy);
      idle(10);
      check("inrun_busy_cycles", 64'(bc), 64'd6);
      check("inrun_done_count", 64'(dc), 64'd1);
      check("inrun_hi", 64'(bus.hi), 64'h0);
      check("inrun_lo", 64'(bus.lo), 64'd12);

      // reset two cycles into a DIVU
      step(1'b1, OP_MTHI, 32'hAB, 32'd0, 1'b0);
      step(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      mid_reset();
      bc = 0;
      dc = 0;
      idle(14);
      check("rst_run_done_count", 64'(dc), 64'd0);
      check("rst_run_busy_cycles", 64'(bc), 64'd0);

`ifdef MDU_MADD_EN
      run_vec(vec_t'{OP_MTLO,  32'd5, 32'd0, 32'h0,        32'd5,        1, 0}, "madd_pre");
      run_vec(vec_t'{OP_MADDU, 32'd2, 32'd3, 32'h0,        32'd11,       6, 1}, "maddu");
      run_vec(vec_t'{OP_MSUBU, 32'd4, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 6, 1}, "msubu");
`endif

      // random traffic, including requests during RUN and divides by zero
      for (int i = 0; i < 600; i++) begin
         r_op = 4'($urandom_range(0, 15));
         r_a  = $urandom;
         r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
         if ($urandom_range(0, 3) == 0) r_a = 32'($urandom_range(0, 40)) - 32'd20;
         step(1'($urandom_range(0, 2) == 0), r_op, r_a, r_b, 1'($urandom_range(0, 9) == 0));
      end
      idle(12);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
